opto_emisync_monitor: RTL and testbench

- Receive-side checker for the laser emission timing strobes: the angle-sync pulse and the GPX2 (TDC) init pulse.
- Measures the sync period and the init-to-sync lead, and qualifies them against expected values.
- Maintains a lock state and reports errors and statistics.
- Sits downstream of the emission-period generator, in the same clock domain, and feeds the status/diagnostic register block.

---
 rtl/opto_emisync_monitor_pkg.sv | 32 +++
 rtl/opto_emisync_monitor_if.sv | 29 ++
 rtl/opto_emisync_monitor_interval.sv | 39 +++
 rtl/opto_emisync_monitor.sv | 154 +++++++++++++++
 tb/tb_opto_emisync_monitor.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/opto_emisync_monitor_pkg.sv
// Shared types, default timing constants and the tolerance compare
// used by the emission-sync monitor.
package opto_emisync_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2,
        S_LOST = 2'd3
    } state_e;

    localparam int unsigned CLK_PERIOD_NS      = 10;
    localparam logic [15:0] DEF_EXP_PERIOD     = 16'd334;
    localparam logic [15:0] DEF_PERIOD_TOL     = 16'd2;
    localparam logic [15:0] DEF_INIT_LEAD      = 16'd34;
    localparam logic [15:0] DEF_LEAD_TOL       = 16'd2;
    localparam logic [7:0]  DEF_LOCK_CNT       = 8'd8;
    localparam logic        DEF_INIT_CHECK_EN  = 1'b1;

    // |meas - exp| <= tol, evaluated one bit wider so nothing wraps.
    function automatic logic in_tol(input logic [15:0] meas,
                                    input logic [15:0] exp_val,
                                    input logic [15:0] tol);
        logic [16:0] diff;
        if (meas >= exp_val)
            diff = {1'b0, meas} - {1'b0, exp_val};
        else
            diff = {1'b0, exp_val} - {1'b0, meas};
        return diff <= {1'b0, tol};
    endfunction

endpackage

// File: rtl/opto_emisync_monitor_if.sv
// Strobe inputs and status/diagnostic outputs of the emission-sync monitor.
interface opto_emisync_monitor_if;

    logic        i_angle_sync;
    logic        i_gpx2_init;
    logic        i_clr_stat;
    logic        o_locked;
    logic [15:0] o_period;
    logic [15:0] o_lead;
    logic        o_period_err;
    logic        o_lead_err;
    logic        o_init_miss;
    logic        o_timeout;
    logic [15:0] o_err_cnt;
    logic [31:0] o_sync_cnt;

    modport master (
        output i_angle_sync, i_gpx2_init, i_clr_stat,
        input  o_locked, o_period, o_lead, o_period_err, o_lead_err,
               o_init_miss, o_timeout, o_err_cnt, o_sync_cnt
    );

    modport slave (
        input  i_angle_sync, i_gpx2_init, i_clr_stat,
        output o_locked, o_period, o_lead, o_period_err, o_lead_err,
               o_init_miss, o_timeout, o_err_cnt, o_sync_cnt
    );

endinterface

// File: rtl/opto_emisync_monitor_interval.sv
// Saturating interval counter: restarts at 1 after start_i and latches
// its running value into meas_o on capture_i.
module opto_interval_meas (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        capture_i,
    output logic [15:0] cnt_o,
    output logic [15:0] meas_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] meas_q, meas_d;

    always_comb begin
        cnt_d  = cnt_q;
        meas_d = meas_q;
        if (start_i)
            cnt_d = 16'd1;
        else if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        if (capture_i)
            meas_d = cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 16'd0;
            meas_q <= 16'd0;
        end else begin
            cnt_q  <= cnt_d;
            meas_q <= meas_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign meas_o = meas_q;

endmodule

// File: rtl/opto_emisync_monitor.sv
// Checks sync period and init-to-sync lead, tracks lock, counts errors/syncs.
//   state  | meaning
//   S_IDLE | no sync seen since reset
//   S_ACQ  | reference taken, counting consecutive good periods
//   S_LOCK | LOCK_CNT good periods seen, lock reported
//   S_LOST | sync absent too long, waiting for a new reference
module opto_emisync_monitor
    import opto_emisync_monitor_pkg::*;
#(
    parameter logic [15:0] EXP_PERIOD    = DEF_EXP_PERIOD,
    parameter logic [15:0] PERIOD_TOL    = DEF_PERIOD_TOL,
    parameter logic [15:0] INIT_LEAD     = DEF_INIT_LEAD,
    parameter logic [15:0] LEAD_TOL      = DEF_LEAD_TOL,
    parameter logic [7:0]  LOCK_CNT      = DEF_LOCK_CNT,
    parameter logic        INIT_CHECK_EN = DEF_INIT_CHECK_EN
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    opto_emisync_monitor_if.slave  bus
);

    localparam logic [16:0] TIMEOUT_LIM = {EXP_PERIOD, 1'b0};

    logic        sync, init, clr;
    logic [15:0] period_cnt, period_meas, lead_cnt, lead_meas;
    state_e      state_q;
    logic [7:0]  good_q;
    logic        init_seen_q, locked_q, timeout_q;
    logic        perr_q, lerr_q, miss_q;
    logic        perr_d, lerr_d, miss_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] sync_cnt_q, sync_cnt_d;
    logic        tracking, checking, period_ok, lead_ok, timeout_hit;
    logic [1:0]  err_add;
    logic [16:0] err_sum;

    assign sync = bus.i_angle_sync;
    assign init = bus.i_gpx2_init;
    assign clr  = bus.i_clr_stat;

    opto_interval_meas u_period (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .start_i   (sync),
        .capture_i (sync),
        .cnt_o     (period_cnt),
        .meas_o    (period_meas)
    );

    // A lead is only meaningful when an init arrived since the last sync.
    opto_interval_meas u_lead (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .start_i   (init),
        .capture_i (sync & init_seen_q),
        .cnt_o     (lead_cnt),
        .meas_o    (lead_meas)
    );

    assign tracking    = (state_q == S_ACQ) || (state_q == S_LOCK);
    assign checking    = sync & tracking;
    assign period_ok   = in_tol(period_cnt, EXP_PERIOD, PERIOD_TOL);
    assign lead_ok     = in_tol(lead_cnt, INIT_LEAD, LEAD_TOL);
    assign timeout_hit = ~sync & tracking & ({1'b0, period_cnt} > TIMEOUT_LIM);

    assign perr_d = checking & ~period_ok;
    assign miss_d = checking & INIT_CHECK_EN & ~init_seen_q;
    assign lerr_d = checking & INIT_CHECK_EN & init_seen_q & ~lead_ok;

    assign err_add = {1'b0, perr_d} + {1'b0, lerr_d} + {1'b0, miss_d};
    assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_add};

    always_comb begin
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        sync_cnt_d = sync ? sync_cnt_q + 32'd1 : sync_cnt_q;
        if (clr) begin
            err_cnt_d  = 16'd0;
            sync_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            good_q      <= 8'd0;
            init_seen_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            perr_q      <= 1'b0;
            lerr_q      <= 1'b0;
            miss_q      <= 1'b0;
            err_cnt_q   <= 16'd0;
            sync_cnt_q  <= 32'd0;
        end else begin
            perr_q      <= perr_d;
            lerr_q      <= lerr_d;
            miss_q      <= miss_d;
            timeout_q   <= 1'b0;
            err_cnt_q   <= err_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            // A coincident init belongs to the next period.
            init_seen_q <= sync ? init : (init_seen_q | init);
            case (state_q)
                S_IDLE, S_LOST: begin
                    if (sync) begin
                        state_q <= S_ACQ;
                        good_q  <= 8'd0;
                    end
                end
                S_ACQ: begin
                    if (sync) begin
                        if (period_ok) begin
                            good_q <= good_q + 8'd1;
                            if (good_q + 8'd1 == LOCK_CNT) begin
                                state_q  <= S_LOCK;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_q <= 8'd0;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= S_LOST;
                        timeout_q <= 1'b1;
                    end
                end
                S_LOCK: begin
                    if (sync) begin
                        if (!period_ok) begin
                            state_q  <= S_ACQ;
                            good_q   <= 8'd0;
                            locked_q <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= S_LOST;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_locked     = locked_q;
    assign bus.o_period     = period_meas;
    assign bus.o_lead       = lead_meas;
    assign bus.o_period_err = perr_q;
    assign bus.o_lead_err   = lerr_q;
    assign bus.o_init_miss  = miss_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_err_cnt    = err_cnt_q;
    assign bus.o_sync_cnt   = sync_cnt_q;

endmodule

// File: tb/tb_opto_emisync_monitor.sv
// Randomized bench for opto_emisync_monitor against a timestamp-based
// reference model; every output is compared every cycle.
module tb_opto_emisync_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    opto_emisync_monitor_if bus ();

    opto_emisync_monitor dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: cycle timestamps of the last sync / init.
    int        t, ps, ls, good;
    bit        flag, has_ref, locked;
    int        e_period, e_lead, e_err;
    bit        e_perr, e_lerr, e_miss, e_to;
    bit [31:0] e_sync;

    function automatic void model_reset();
        t = 0; ps = 0; ls = 0; good = 0;
        flag = 0; has_ref = 0; locked = 0;
        e_period = 0; e_lead = 0; e_err = 0; e_sync = 0;
        e_perr = 0; e_lerr = 0; e_miss = 0; e_to = 0;
    endfunction

    function automatic void model_step(input bit s, input bit in, input bit c);
        int p, l, d;
        p = (t - ps > 65535) ? 65535 : t - ps;
        l = (t - ls > 65535) ? 65535 : t - ls;
        e_perr = 0; e_lerr = 0; e_miss = 0; e_to = 0;
        if (s) begin
            e_sync   = e_sync + 1;
            e_period = p;
            if (flag) e_lead = l;
            if (has_ref) begin
                d      = (p > 334) ? p - 334 : 334 - p;
                e_perr = (d > 2);
                e_miss = !flag;
                d      = (l > 34) ? l - 34 : 34 - l;
                e_lerr = flag && (d > 2);
                if (e_perr) begin
                    good   = 0;
                    locked = 0;
                end else if (!locked) begin
                    good++;
                    if (good == 8) locked = 1;
                end
            end else begin
                has_ref = 1;
                good    = 0;
            end
            ps = t;
        end else if (has_ref && p > 668) begin
            has_ref = 0;
            locked  = 0;
            e_to    = 1;
        end
        e_err = e_err + int'(e_perr) + int'(e_lerr) + int'(e_miss);
        if (e_err > 65535) e_err = 65535;
        if (c) begin
            e_err  = 0;
            e_sync = 0;
        end
        if (in) ls = t;
        flag = s ? in : (flag | in);
        t++;
    endfunction

    task automatic check_outputs();
        check_val("locked",     bus.o_locked,     locked);
        check_val("period",     bus.o_period,     e_period);
        check_val("lead",       bus.o_lead,       e_lead);
        check_val("period_err", bus.o_period_err, e_perr);
        check_val("lead_err",   bus.o_lead_err,   e_lerr);
        check_val("init_miss",  bus.o_init_miss,  e_miss);
        check_val("timeout",    bus.o_timeout,    e_to);
        check_val("err_cnt",    bus.o_err_cnt,    e_err);
        check_val("sync_cnt",   bus.o_sync_cnt,   e_sync);
    endtask

    task automatic tick(input bit s, input bit in, input bit c);
        @(negedge clk);
        check_outputs();
        bus.i_angle_sync = s;
        bus.i_gpx2_init  = in;
        bus.i_clr_stat   = c;
        model_step(s, in, c);
    endtask

    // Let the last driven cycle clock in, without consuming an extra cycle.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_period(input int interval, input int lead, input bit has_init, input int clr_k);
        for (int k = 1; k <= interval; k++)
            tick(k == interval, has_init && (k == interval - lead), k == clr_k);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0);
    endtask

    task automatic apply_reset(input bit running);
        @(negedge clk);
        if (running) check_outputs();
        rst = 1'b1;
        bus.i_angle_sync = 1'b0;
        bus.i_gpx2_init  = 1'b0;
        bus.i_clr_stat   = 1'b0;
        #1;
        if (running) begin
            check_val("rst_locked",   bus.o_locked,     0);
            check_val("rst_period",   bus.o_period,     0);
            check_val("rst_lead",     bus.o_lead,       0);
            check_val("rst_perr",     bus.o_period_err, 0);
            check_val("rst_lerr",     bus.o_lead_err,   0);
            check_val("rst_miss",     bus.o_init_miss,  0);
            check_val("rst_timeout",  bus.o_timeout,    0);
            check_val("rst_err_cnt",  bus.o_err_cnt,    0);
            check_val("rst_sync_cnt", bus.o_sync_cnt,   0);
        end
        @(negedge clk);
        check_val("rst_hold_sync_cnt", bus.o_sync_cnt, 0);
        rst = 1'b0;
        model_reset();
        model_step(0, 0, 0);
    endtask

    initial begin
        int iv, ld, r;
        bit hi;
        bus.i_angle_sync = 1'b0;
        bus.i_gpx2_init  = 1'b0;
        bus.i_clr_stat   = 1'b0;
        apply_reset(0);

        // Acquire: reference sync + 8 good periods.
        for (int i = 0; i < 8; i++) run_period(334, 34, 1, 0);
        settle();
        check_val("not_locked_8th", bus.o_locked, 0);
        run_period(334, 34, 1, 0);
        settle();
        check_val("locked_9th", bus.o_locked, 1);
        check_val("period_334", bus.o_period, 334);
        check_val("lead_34",    bus.o_lead, 34);
        check_val("no_errors",  bus.o_err_cnt, 0);

        // Long interval drops lock, 8 good periods relock.
        run_period(340, 34, 1, 0);
        settle();
        check_val("perr_340",    bus.o_period_err, 1);
        check_val("unlock_340",  bus.o_locked, 0);
        check_val("errcnt_340",  bus.o_err_cnt, 1);
        for (int i = 0; i < 7; i++) run_period(334, 34, 1, 0);
        run_period(334, 34, 1, 0);
        settle();
        check_val("relock", bus.o_locked, 1);

        // Tolerance boundaries.
        run_period(336, 34, 1, 0);
        settle();
        check_val("perr_336", bus.o_period_err, 0);
        run_period(332, 34, 1, 0);
        settle();
        check_val("perr_332", bus.o_period_err, 0);
        check_val("lock_332", bus.o_locked, 1);
        run_period(337, 34, 1, 0);
        settle();
        check_val("perr_337", bus.o_period_err, 1);
        run_period(331, 34, 1, 0);
        settle();
        check_val("perr_331", bus.o_period_err, 1);
        for (int i = 0; i < 8; i++) run_period(334, 34, 1, 0);

        // Lead / init faults do not drop lock.
        run_period(334, 40, 1, 0);
        settle();
        check_val("lead_40",       bus.o_lead, 40);
        check_val("lerr_40",       bus.o_lead_err, 1);
        check_val("lock_lead_err", bus.o_locked, 1);
        run_period(334, 34, 0, 0);
        settle();
        check_val("init_miss",     bus.o_init_miss, 1);
        check_val("lock_init_miss", bus.o_locked, 1);

        // Clear coincident with a period error.
        run_period(340, 34, 1, 340);
        settle();
        check_val("clr_perr",    bus.o_period_err, 1);
        check_val("clr_err_cnt", bus.o_err_cnt, 0);

        // Randomized periods, leads, missing/coincident inits and clears.
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            iv = (r < 6) ? 332 + $urandom_range(0, 4) :
                 (r < 8) ? 329 + $urandom_range(0, 12) : 334;
            r  = $urandom_range(0, 9);
            hi = (r != 8);
            ld = (r < 7) ? $urandom_range(31, 37) : (r == 7) ? 40 : (r == 9) ? 0 : 34;
            run_period(iv, ld, hi, ($urandom_range(0, 7) == 0) ? $urandom_range(1, iv) : 0);
        end

        // Relock, then lose sync.
        for (int i = 0; i < 9; i++) run_period(334, 34, 1, 0);
        idle(668);
        settle();
        check_val("timeout_early", bus.o_timeout, 0);
        idle(1);
        settle();
        check_val("timeout_pulse", bus.o_timeout, 1);
        check_val("timeout_lock",  bus.o_locked, 0);
        idle(30);

        // Resume: first sync silent, lock after 8 good periods.
        run_period(334, 34, 1, 0);
        settle();
        check_val("resume_silent_perr", bus.o_period_err, 0);
        check_val("resume_silent_miss", bus.o_init_miss, 0);
        for (int i = 0; i < 8; i++) run_period(334, 34, 1, 0);
        settle();
        check_val("resume_locked", bus.o_locked, 1);

        // Reset mid-operation while locked, then reacquire.
        idle(100);
        apply_reset(1);
        for (int i = 0; i < 10; i++) run_period(333 + $urandom_range(0, 2), 34, 1, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
